multi_src_frame_enc: RTL and testbench
======================================

// Module: multi_src_frame_enc
// PURPOSE
//  Parametrised multi-source frame encoder feeding the UART transmitter.
//  Arbitrates NUM_SOURCES show-ahead message FIFOs and serialises one message at a time.
//  Frame format: PREFIX, SRC, DEST, LEN, LEN payload bytes, CRC8.
//  Sits between the per-source message FIFOs and the UART tx byte interface.
// PARAMETERS
//  NUM_SOURCES    4      number of source channels (1..16)
//  PREFIX         8'hDD  frame start byte
//  SRC_ADDR_BASE  8'h01  SRC byte = SRC_ADDR_BASE + channel index
//  DEST_ADDR      8'h00  DEST byte, constant
//  CRC_POLY       8'h07  CRC-8 polynomial: MSB-first, no reflection, no final XOR
//  CRC_INIT       8'h00  CRC preset, loaded at each frame start
// PORTS
//  clk           in   1              system clock
//  n_rst         in   1              async active-low reset
//  have_msg_bus  in   NUM_SOURCES    bit i: source i holds a complete message
//  len_bus       in   8*NUM_SOURCES  payload length of source i, bits [8i+7:8i]
//  data_bus      in   8*NUM_SOURCES  show-ahead head byte of source i
//  rdreq_bus     out  NUM_SOURCES    one-hot pop strobe to the granted source
//  tx_data       out  8              byte to UART tx
//  tx_valid      out  1              tx_data is valid
//  tx_ready      in   1              UART accepts the byte this cycle
//  cur_source    out  $clog2(NUM_SOURCES)  granted channel index
//  busy          out  1              frame in progress
// BEHAVIOUR
//  Reset values:
//   - all outputs are 0 (tx_valid=0, rdreq_bus=0, cur_source=0, busy=0).
//   - State returns to IDLE and CRC loads CRC_INIT.
//  FSM states: IDLE, PREFIX, SRC, DEST, LEN, PAYLOAD, CRC.
//  Byte handshake:
//   - A byte transfers on a cycle where tx_valid & tx_ready are both 1.
//   - tx_data/tx_valid are registered and held stable until the transfer.
//   - The next byte is presented in the cycle after a transfer; this gives 1 byte per 2 clk at most.
//  IDLE:
//   - When have_msg_bus != 0, grant one source and latch its index and len_bus field.
//   - Preset CRC to CRC_INIT.
//   - Go to PREFIX; tx_valid=1 with tx_data=PREFIX on the next cycle.
//  PREFIX -> SRC -> DEST -> LEN: each state advances on its transfer.
//  LEN exit:
//   - If len==0, go to CRC.
//   - Otherwise go to PAYLOAD with the remaining-byte counter set to len.
//  PAYLOAD:
//   - tx_data = granted data_bus byte.
//   - rdreq_bus[grant] is combinational = tx_valid & tx_ready & (state==PAYLOAD).
//   - The counter decrements per transfer; at 1 -> 0, go to CRC.
//  CRC:
//   - Send the final CRC, then go to IDLE.
//   - A new grant is possible in the cycle after the CRC transfer.
//  CRC coverage: SRC, DEST, LEN and payload; PREFIX is excluded.
//   - CRC updates on each covered transfer.
//  Boundary conditions:
//   - len=255 is legal (8-bit counter, no wrap).
//   - have_msg/len of the granted source changing mid-frame is ignored; len is latched.
//   - Other sources requesting mid-frame wait; no pre-emption.
//   - tx_ready held low stalls indefinitely, with no rdreq and no state change.
//   - Reset mid-frame aborts to IDLE immediately.
//     Bytes already popped are lost; no partial CRC is sent.
// CONFIGURATION
//  `ENC_ROUND_ROBIN_EN defined:
//   - Round-robin arbitration; search starts at (last grant + 1) mod NUM_SOURCES.
//   - The last-grant pointer resets to NUM_SOURCES-1, so channel 0 wins first.
//  Undefined: fixed priority, lowest requesting index wins.
// STRUCTURE
//  enc_pkg: FSM state encoding, default PREFIX/CRC_POLY/CRC_INIT constants.
//  Sub-module crc8_byte:
//   - Combinational 8-bit CRC update of (crc, byte) for CRC_POLY.
//   - Instanced once.
// TESTING
//  1 Source 0 msg len=1 payload AA, tx_ready=1
//    -> bytes DD 01 00 01 AA 5C; exactly 1 rdreq_bus[0] pulse.
//  2 Source 0 msg len=0
//    -> DD 01 00 00 6B; no rdreq pulses.
//  3 Sources 0 and 2 both requesting
//    -> two complete frames, SRC 01 then 03, never interleaved.
//    -> repeat with 2 left requesting:
//       with _RR_EN, 03 is granted next;
//       without it, 01 keeps winning whenever it requests.
//  4 tx_ready toggled randomly, len=6 payload 01..06
//    -> tx_data stable while stalled; 6 rdreqs; CRC matches bench model.
//  5 n_rst pulsed low mid-PAYLOAD
//    -> tx_valid=0 and busy=0 immediately; next frame restarts with DD, CRC preset.
//  6 len=255
//    -> 259+1 byte frame, 255 rdreqs, counter does not wrap, returns to IDLE.

Source files
------------

// File: rtl/multi_src_frame_enc_pkg.sv
// multi_src_frame_enc_pkg: FSM state encoding and default frame/CRC constants shared by the frame encoder
package multi_src_frame_enc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_SRC, S_DEST, S_LEN, S_PAYLOAD, S_CRC} state_e;
  localparam logic [7:0] DEF_PREFIX   = 8'hDD;
  localparam logic [7:0] DEF_CRC_POLY = 8'h07;
  localparam logic [7:0] DEF_CRC_INIT = 8'h00;
endpackage

// File: rtl/multi_src_frame_enc_if.sv
// multi_src_frame_enc_if: per-source FIFO signals and UART tx byte handshake of the frame encoder
interface multi_src_frame_enc_if #(parameter int NUM_SOURCES = 4);
  logic [NUM_SOURCES-1:0]   have_msg_bus;
  logic [NUM_SOURCES-1:0]   rdreq_bus;
  logic [8*NUM_SOURCES-1:0] len_bus;
  logic [8*NUM_SOURCES-1:0] data_bus;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  modport master (input have_msg_bus, len_bus, data_bus, tx_ready, output rdreq_bus, tx_data, tx_valid);
  modport slave (output have_msg_bus, len_bus, data_bus, tx_ready, input rdreq_bus, tx_data, tx_valid);
endinterface

// File: rtl/multi_src_frame_enc_crc8_byte.sv
// multi_src_frame_enc_crc8_byte: combinational CRC-8 update of one byte, MSB-first, no reflection
module multi_src_frame_enc_crc8_byte #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic [7:0] crc_i,
  input  logic [7:0] byte_i,
  output logic [7:0] crc_o
);
  always_comb begin
    crc_o = crc_i ^ byte_i;
    for (int b = 0; b < 8; b++) crc_o = crc_o[7] ? (crc_o << 1) ^ POLY : crc_o << 1;
  end
endmodule

// File: rtl/multi_src_frame_enc.sv
// multi_src_frame_enc: arbitrates NUM_SOURCES message FIFOs into PREFIX/SRC/DEST/LEN/payload/CRC8 frames.
// Define ENC_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module multi_src_frame_enc
  import multi_src_frame_enc_pkg::*;
#(
  parameter int         NUM_SOURCES   = 4,
  parameter logic [7:0] PREFIX        = DEF_PREFIX,
  parameter logic [7:0] SRC_ADDR_BASE = 8'h01,
  parameter logic [7:0] DEST_ADDR     = 8'h00,
  parameter logic [7:0] CRC_POLY      = DEF_CRC_POLY,
  parameter logic [7:0] CRC_INIT      = DEF_CRC_INIT,
  localparam int        SW            = NUM_SOURCES > 1 ? $clog2(NUM_SOURCES) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  multi_src_frame_enc_if.master bus,
  output logic [SW-1:0] cur_source,
  output logic          busy
);
  state_e        state_q, state_d;
  logic [SW-1:0] grant_q, pick, idx;
  logic [7:0]    len_q, cnt_q, crc_q, crc_nx, tx_data_q, byte_d;
  logic          tx_valid_q, busy_q, xfer;
  int            rr_base;
`ifdef ENC_ROUND_ROBIN_EN
  logic [SW-1:0] last_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) last_q <= SW'(NUM_SOURCES - 1);
    else if (state_q == S_IDLE && |bus.have_msg_bus) last_q <= pick;
  assign rr_base = int'(last_q) + 1;
`else
  assign rr_base = 0;
`endif
  // search from rr_base upward; the last hit of the descending loop is the first in search order
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      idx = SW'((rr_base + k) % NUM_SOURCES);
      if (bus.have_msg_bus[idx]) pick = idx;
    end
  end
  assign xfer = tx_valid_q & bus.tx_ready;
  assign byte_d = state_q == S_SRC     ? SRC_ADDR_BASE + 8'(grant_q) :
                  state_q == S_DEST    ? DEST_ADDR :
                  state_q == S_LEN     ? len_q :
                  state_q == S_PAYLOAD ? bus.data_bus[{grant_q, 3'b000} +: 8] : crc_q;
  assign state_d = state_q == S_PREFIX  ? S_SRC :
                   state_q == S_SRC     ? S_DEST :
                   state_q == S_DEST    ? S_LEN :
                   state_q == S_LEN     ? (len_q == 8'd0 ? S_CRC : S_PAYLOAD) :
                   state_q == S_PAYLOAD ? (cnt_q == 8'd1 ? S_CRC : S_PAYLOAD) : S_IDLE;
  multi_src_frame_enc_crc8_byte #(.POLY(CRC_POLY)) u_crc (.crc_i(crc_q), .byte_i(tx_data_q), .crc_o(crc_nx));
  // a transfer drops tx_valid for one cycle so a popped FIFO head settles before it is captured
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (|bus.have_msg_bus) begin
        grant_q    <= pick;
        len_q      <= bus.len_bus[{pick, 3'b000} +: 8];
        crc_q      <= CRC_INIT;
        tx_data_q  <= PREFIX;
        tx_valid_q <= 1'b1;
        busy_q     <= 1'b1;
        state_q    <= S_PREFIX;
      end
    end else if (!tx_valid_q) begin
      tx_data_q  <= byte_d;
      tx_valid_q <= 1'b1;
    end else if (xfer) begin
      tx_valid_q <= 1'b0;
      state_q    <= state_d;
      if (state_q inside {S_SRC, S_DEST, S_LEN, S_PAYLOAD}) crc_q <= crc_nx;
      if (state_q == S_LEN) cnt_q <= len_q;
      if (state_q == S_PAYLOAD) cnt_q <= cnt_q - 8'd1;
      if (state_q == S_CRC) busy_q <= 1'b0;
    end
  end
  assign bus.rdreq_bus = NUM_SOURCES'(xfer && state_q == S_PAYLOAD) << grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign cur_source    = grant_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_multi_src_frame_enc.sv
// tb_multi_src_frame_enc: randomized frame checks against a queue-based source and frame model
module tb_multi_src_frame_enc;
  localparam int NS = 4;
  logic clk, n_rst;
  logic [1:0] cur_source;
  logic busy;
  multi_src_frame_enc_if #(.NUM_SOURCES(NS)) bus ();
  multi_src_frame_enc #(.NUM_SOURCES(NS)) dut (.clk(clk), .n_rst(n_rst), .bus(bus), .cur_source(cur_source), .busy(busy));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int pass_n = 0, total_n = 0;
  int sl_q [NS][$];
  logic [7:0] sb_q [NS][$];
  int ml_q [NS][$];
  logic [7:0] mb_q [NS][$];
  logic [7:0] stage_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];
  int last_m = NS - 1;
  bit rand_ready = 0;
  int pos = 0, msrc = 0, mlen = 0, rd_bad = 0, stall_bad = 0;
  int rdreq_cnt [NS];
  bit prev_v = 0, prev_x = 0, xf;
  logic [7:0] prev_d;
  logic [NS-1:0] exp_rd;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // source FIFOs + UART sink: drive at negedge, observe the upcoming edge's transfer 1ns later
  always @(negedge clk) begin
    bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < NS; i++) begin
      bus.have_msg_bus[i] = sl_q[i].size() > 0;
      bus.len_bus[8*i +: 8] = sl_q[i].size() > 0 ? 8'(sl_q[i][0]) : 8'h00;
      bus.data_bus[8*i +: 8] = sb_q[i].size() > 0 ? sb_q[i][0] : 8'h00;
    end
    #1;
    if (!n_rst) begin
      pos = 0;
      prev_v = 0;
    end else begin
      xf = bus.tx_valid && bus.tx_ready;
      if (prev_v && !prev_x && (!bus.tx_valid || bus.tx_data !== prev_d)) stall_bad++;
      exp_rd = '0;
      if (xf) begin
        if (pos == 1) msrc = int'(bus.tx_data) - 1;
        if (pos == 3) mlen = int'(bus.tx_data);
        if (pos >= 4 && pos < 4 + mlen && msrc >= 0 && msrc < NS) exp_rd[msrc] = 1'b1;
        rx_q.push_back(bus.tx_data);
      end
      if (bus.rdreq_bus !== exp_rd) rd_bad++;
      for (int i = 0; i < NS; i++)
        if (bus.rdreq_bus[i] === 1'b1) begin
          rdreq_cnt[i]++;
          if (sb_q[i].size() > 0) void'(sb_q[i].pop_front());
        end
      if (xf) begin
        if (pos >= 4 && pos == 4 + mlen) begin
          pos = 0;
          if (msrc >= 0 && msrc < NS && sl_q[msrc].size() > 0) void'(sl_q[msrc].pop_front());
        end else pos++;
      end
      prev_v = bus.tx_valid;
      prev_x = xf;
      prev_d = bus.tx_data;
    end
  end

  task automatic clear_obs();
    rx_q.delete();
    for (int i = 0; i < NS; i++) rdreq_cnt[i] = 0;
    rd_bad = 0;
    stall_bad = 0;
  endtask

  task automatic stage_rand(input int n);
    stage_q.delete();
    for (int i = 0; i < n; i++) stage_q.push_back(8'($urandom));
  endtask

  task automatic push_msg(input int s);
    sl_q[s].push_back(stage_q.size());
    ml_q[s].push_back(stage_q.size());
    foreach (stage_q[i]) begin
      sb_q[s].push_back(stage_q[i]);
      mb_q[s].push_back(stage_q[i]);
    end
  endtask

  // frame order follows the arbitration rule over everything pending in the model
  task automatic build_expected();
    int p, len, idx;
    logic [7:0] c, b;
    exp_q.delete();
    while (1) begin
      p = -1;
      for (int o = 0; o < NS; o++) begin
`ifdef ENC_ROUND_ROBIN_EN
        idx = (last_m + 1 + o) % NS;
`else
        idx = o;
`endif
        if (p < 0 && ml_q[idx].size() > 0) p = idx;
      end
      if (p < 0) break;
      last_m = p;
      len = ml_q[p].pop_front();
      c = 8'h00;
      exp_q.push_back(8'hDD);
      b = 8'(p + 1); exp_q.push_back(b); c = crc8(c, b);
      b = 8'h00;     exp_q.push_back(b); c = crc8(c, b);
      b = 8'(len);   exp_q.push_back(b); c = crc8(c, b);
      repeat (len) begin
        b = mb_q[p].pop_front();
        exp_q.push_back(b);
        c = crc8(c, b);
      end
      exp_q.push_back(c);
    end
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #2;
      if (rx_q.size() >= n && !busy) begin
        ok = 1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    total_n++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); else pass_n++;
    total_n++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else pass_n++;
    total_n++; if (bus.rdreq_bus !== 4'h0) $display("FAIL reset_rdreq: got %b want 0000", bus.rdreq_bus); else pass_n++;
    total_n++; if (cur_source !== 2'd0) $display("FAIL reset_cur_source: got %0d want 0", cur_source); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_n++;
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    total_n++; if (busy !== 1'b0 || bus.tx_valid !== 1'b0) $display("FAIL idle_no_req: busy %b tx_valid %b want 0 0", busy, bus.tx_valid); else pass_n++;
  endtask

  task automatic test_single();
    logic [7:0] ref_b [6] = '{8'hDD, 8'h01, 8'h00, 8'h01, 8'hAA, 8'h5C};
    bit ok;
    int got;
    clear_obs();
    stage_q = '{8'hAA};
    push_msg(0);
    build_expected();
    wait_done(6, 100, ok);
    total_n++; if (!ok) $display("FAIL single_done: timeout with %0d bytes, want 6", rx_q.size()); else pass_n++;
    total_n++; if (rx_q.size() != 6) $display("FAIL single_len: got %0d bytes want 6", rx_q.size()); else pass_n++;
    for (int k = 0; k < 6; k++) begin
      got = k < rx_q.size() ? int'(rx_q[k]) : -1;
      total_n++; if (got != int'(ref_b[k])) $display("FAIL single_byte%0d: got %h want %h", k, got, ref_b[k]); else pass_n++;
    end
    total_n++; if (rdreq_cnt[0] != 1 || rdreq_cnt[1] + rdreq_cnt[2] + rdreq_cnt[3] != 0) $display("FAIL single_rdreq: src0 %0d others %0d want 1 0", rdreq_cnt[0], rdreq_cnt[1] + rdreq_cnt[2] + rdreq_cnt[3]); else pass_n++;
    total_n++; if (rd_bad != 0) $display("FAIL single_rdreq_timing: %0d bad cycles want 0", rd_bad); else pass_n++;
  endtask

  task automatic test_zero_len();
    logic [7:0] ref_b [5] = '{8'hDD, 8'h01, 8'h00, 8'h00, 8'h6B};
    bit ok;
    int got;
    clear_obs();
    stage_q.delete();
    push_msg(0);
    build_expected();
    wait_done(5, 100, ok);
    total_n++; if (!ok || rx_q.size() != 5) $display("FAIL zero_len_size: got %0d bytes ok %b want 5", rx_q.size(), ok); else pass_n++;
    for (int k = 0; k < 5; k++) begin
      got = k < rx_q.size() ? int'(rx_q[k]) : -1;
      total_n++; if (got != int'(ref_b[k])) $display("FAIL zero_len_byte%0d: got %h want %h", k, got, ref_b[k]); else pass_n++;
    end
    total_n++; if (rdreq_cnt[0] + rdreq_cnt[1] + rdreq_cnt[2] + rdreq_cnt[3] != 0 || rd_bad != 0) $display("FAIL zero_len_rdreq: %0d pulses %0d bad want 0 0", rdreq_cnt[0] + rdreq_cnt[1] + rdreq_cnt[2] + rdreq_cnt[3], rd_bad); else pass_n++;
  endtask

  task automatic test_arbitration();
    bit ok;
    int got;
    int srcs [2][] = '{'{0, 2}, '{0, 0, 2}};
    for (int ph = 0; ph < 2; ph++) begin
      clear_obs();
      foreach (srcs[ph][j]) begin
        stage_rand($urandom_range(0, 5));
        push_msg(srcs[ph][j]);
      end
      build_expected();
      wait_done(exp_q.size(), 300, ok);
      total_n++; if (!ok || rx_q.size() != exp_q.size()) $display("FAIL arb%0d_size: got %0d bytes ok %b want %0d", ph, rx_q.size(), ok, exp_q.size()); else pass_n++;
      foreach (exp_q[k]) begin
        got = k < rx_q.size() ? int'(rx_q[k]) : -1;
        total_n++; if (got != int'(exp_q[k])) $display("FAIL arb%0d_byte%0d: got %h want %h", ph, k, got, exp_q[k]); else pass_n++;
      end
      total_n++; if (rd_bad != 0) $display("FAIL arb%0d_rdreq: %0d bad cycles want 0", ph, rd_bad); else pass_n++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    int got;
    clear_obs();
    rand_ready = 1;
    stage_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    push_msg(1);
    build_expected();
    wait_done(exp_q.size(), 400, ok);
    rand_ready = 0;
    total_n++; if (!ok || rx_q.size() != exp_q.size()) $display("FAIL stall_size: got %0d bytes ok %b want %0d", rx_q.size(), ok, exp_q.size()); else pass_n++;
    foreach (exp_q[k]) begin
      got = k < rx_q.size() ? int'(rx_q[k]) : -1;
      total_n++; if (got != int'(exp_q[k])) $display("FAIL stall_byte%0d: got %h want %h", k, got, exp_q[k]); else pass_n++;
    end
    total_n++; if (stall_bad != 0) $display("FAIL stall_hold: %0d unstable cycles want 0", stall_bad); else pass_n++;
    total_n++; if (rdreq_cnt[1] != 6 || rd_bad != 0) $display("FAIL stall_rdreq: %0d pulses %0d bad want 6 0", rdreq_cnt[1], rd_bad); else pass_n++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int got;
    clear_obs();
    stage_rand(20);
    push_msg(3);
    build_expected();
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (pos >= 7) begin
        ok = 1;
        break;
      end
    end
    total_n++; if (!ok) $display("FAIL midrst_reach: payload pos %0d want >= 7", pos); else pass_n++;
    n_rst = 1'b0;
    #1;
    total_n++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_async: tx_valid %b busy %b want 0 0", bus.tx_valid, busy); else pass_n++;
    total_n++; if (bus.rdreq_bus !== 4'h0 || cur_source !== 2'd0) $display("FAIL midrst_outs: rdreq %b cur_source %0d want 0000 0", bus.rdreq_bus, cur_source); else pass_n++;
    for (int i = 0; i < NS; i++) begin
      sl_q[i].delete();
      sb_q[i].delete();
      ml_q[i].delete();
      mb_q[i].delete();
    end
    last_m = NS - 1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    clear_obs();
    stage_rand(3);
    push_msg(1);
    build_expected();
    wait_done(exp_q.size(), 100, ok);
    total_n++; if (!ok || rx_q.size() != exp_q.size()) $display("FAIL midrst_size: got %0d bytes ok %b want %0d", rx_q.size(), ok, exp_q.size()); else pass_n++;
    foreach (exp_q[k]) begin
      got = k < rx_q.size() ? int'(rx_q[k]) : -1;
      total_n++; if (got != int'(exp_q[k])) $display("FAIL midrst_byte%0d: got %h want %h", k, got, exp_q[k]); else pass_n++;
    end
  endtask

  task automatic test_max_len();
    bit ok;
    int got, bad;
    clear_obs();
    stage_rand(255);
    push_msg(2);
    build_expected();
    wait_done(exp_q.size(), 1500, ok);
    total_n++; if (!ok || rx_q.size() != 260) $display("FAIL max_size: got %0d bytes ok %b want 260", rx_q.size(), ok); else pass_n++;
    bad = 0;
    foreach (exp_q[k]) begin
      got = k < rx_q.size() ? int'(rx_q[k]) : -1;
      if (got != int'(exp_q[k])) bad++;
    end
    total_n++; if (bad != 0) $display("FAIL max_bytes: %0d wrong bytes want 0", bad); else pass_n++;
    total_n++; if (rx_q.size() > 0 && rx_q[rx_q.size()-1] !== exp_q[259]) $display("FAIL max_crc: got %h want %h", rx_q[rx_q.size()-1], exp_q[259]); else pass_n++;
    total_n++; if (rdreq_cnt[2] != 255 || rd_bad != 0) $display("FAIL max_rdreq: %0d pulses %0d bad want 255 0", rdreq_cnt[2], rd_bad); else pass_n++;
    total_n++; if (busy !== 1'b0 || bus.tx_valid !== 1'b0) $display("FAIL max_idle: busy %b tx_valid %b want 0 0", busy, bus.tx_valid); else pass_n++;
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_zero_len();
    test_arbitration();
    test_stall();
    test_reset_mid_frame();
    test_max_len();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
